// File: rtl/wb_arbiter_pkg.sv
// Shared constants and requester identifiers for the register-file writeback arbiter.
package wb_arbiter_pkg;

  localparam int REG_AWIDTH = 5;
  localparam int REG_DWIDTH = 32;

  typedef enum logic {
    REQ_ALU = 1'b0,
    REQ_LSU = 1'b1
  } req_id_e;

  localparam logic [REG_AWIDTH-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the priority bit points at the requester that lost last.
module rr_arb2
  import wb_arbiter_pkg::*;
(
  input  logic       r_clk,
  input  logic       r_rst,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  req_id_e r_prio;

  always_comb begin
    // NOTE: default assigned first so every path drives o_gnt; no latch is inferred.
    o_gnt = 2'b00;
    if (!r_rst) begin
      if (i_req[REQ_ALU] && i_req[REQ_LSU]) begin
        o_gnt[r_prio] = 1'b1;
      end else begin
        o_gnt = i_req;
      end
    end
  end

  always_ff @(posedge r_clk) begin
    // NOTE: non-blocking assignment for all clocked state avoids ordering races between blocks.
    if (r_rst) begin
      r_prio <= REQ_ALU;
    end else if (o_gnt[REQ_ALU]) begin
      r_prio <= REQ_LSU;
    end else if (o_gnt[REQ_LSU]) begin
      r_prio <= REQ_ALU;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the register-file write port between ALU and LSU, with a
// one-entry output stage and a bypass for reads that hit the in-flight write.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int AWIDTH = REG_AWIDTH,
  parameter int DWIDTH = REG_DWIDTH
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [AWIDTH-1:0] alu_addr,
  input  logic [DWIDTH-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [AWIDTH-1:0] lsu_addr,
  input  logic [DWIDTH-1:0] lsu_data,
  output logic              r_we,
  output logic [AWIDTH-1:0] r_addr_rd,
  output logic [DWIDTH-1:0] r_data_rd,
  input  logic [AWIDTH-1:0] byp_addr_rs1,
  input  logic [AWIDTH-1:0] byp_addr_rs2,
  output logic              byp_hit_rs1,
  output logic              byp_hit_rs2,
  output logic [DWIDTH-1:0] byp_data_rs1,
  output logic [DWIDTH-1:0] byp_data_rs2
);

  logic [1:0]        w_req;
  logic [1:0]        w_gnt;
  logic              w_any;
  logic [AWIDTH-1:0] w_addr;
  logic [DWIDTH-1:0] w_data;

  assign w_req = {lsu_valid, alu_valid};

  rr_arb2 u_rr_arb2 (
    .r_clk (r_clk),
    .r_rst (r_rst),
    .i_req (w_req),
    .o_gnt (w_gnt)
  );

  assign alu_ready = w_gnt[REQ_ALU];
  assign lsu_ready = w_gnt[REQ_LSU];
  assign w_any     = |w_gnt;

  always_comb begin
    w_addr = alu_addr;
    w_data = alu_data;
    if (w_gnt[REQ_LSU]) begin
      w_addr = lsu_addr;
      w_data = lsu_data;
    end
  end

  // Writes to x0 are accepted but never reach the register file.
  always_ff @(posedge r_clk) begin
    if (r_rst) begin
      r_we      <= 1'b0;
      r_addr_rd <= '0;
      r_data_rd <= '0;
    end else if (w_any) begin
      r_we      <= (w_addr != AWIDTH'(REG_ZERO));
      r_addr_rd <= w_addr;
      r_data_rd <= w_data;
    end else begin
      r_we      <= 1'b0;
    end
  end

  assign byp_hit_rs1  = r_we && (r_addr_rd == byp_addr_rs1) && (byp_addr_rs1 != AWIDTH'(REG_ZERO));
  assign byp_hit_rs2  = r_we && (r_addr_rd == byp_addr_rs2) && (byp_addr_rs2 != AWIDTH'(REG_ZERO));
  assign byp_data_rs1 = byp_hit_rs1 ? r_data_rd : '0;
  assign byp_data_rs2 = byp_hit_rs2 ? r_data_rd : '0;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a request-level model predicts grants and the
// output stage each cycle; a monitor compares the DUT's write port and bypass outputs.
module tb_wb_arbiter;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
  } out_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } txn_t;

  localparam int ALU = 0;
  localparam int LSU = 1;

  logic        r_clk = 1'b0;
  logic        r_rst;
  logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
  logic [4:0]  alu_addr, lsu_addr;
  logic [31:0] alu_data, lsu_data;
  logic        r_we;
  logic [4:0]  r_addr_rd;
  logic [31:0] r_data_rd;
  logic [4:0]  byp_addr_rs1, byp_addr_rs2;
  logic        byp_hit_rs1, byp_hit_rs2;
  logic [31:0] byp_data_rs1, byp_data_rs2;

  wb_arbiter dut (
    .r_clk        (r_clk),
    .r_rst        (r_rst),
    .alu_valid    (alu_valid),
    .alu_ready    (alu_ready),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .lsu_valid    (lsu_valid),
    .lsu_ready    (lsu_ready),
    .lsu_addr     (lsu_addr),
    .lsu_data     (lsu_data),
    .r_we         (r_we),
    .r_addr_rd    (r_addr_rd),
    .r_data_rd    (r_data_rd),
    .byp_addr_rs1 (byp_addr_rs1),
    .byp_addr_rs2 (byp_addr_rs2),
    .byp_hit_rs1  (byp_hit_rs1),
    .byp_hit_rs2  (byp_hit_rs2),
    .byp_data_rs1 (byp_data_rs1),
    .byp_data_rs2 (byp_data_rs2)
  );

  always #5 r_clk = ~r_clk;

  int          n_checks = 0;
  int          n_errors = 0;

  out_t        exp_q[$];
  txn_t        alu_q[$];
  txn_t        lsu_q[$];
  logic [31:0] m_rf[32];
  logic [31:0] tb_rf[32];
  out_t        m_out;
  int          m_last_winner;
  bit          g_alu, g_lsu;
  bit          gaps, byp_auto;

  // Register file driven only by the DUT's write port.
  always @(posedge r_clk) begin
    if (r_we === 1'b1) tb_rf[r_addr_rd] <= r_data_rd;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decides the winner from the request rules and predicts next cycle's output stage.
  task automatic model_step();
    int win;
    win = -1;
    if (r_rst) begin
      m_last_winner = LSU;
      m_out = '0;
    end else begin
      if (alu_valid && lsu_valid) win = (m_last_winner == ALU) ? LSU : ALU;
      else if (alu_valid)         win = ALU;
      else if (lsu_valid)         win = LSU;
      if (win == ALU) begin
        m_out = '{we: (alu_addr != 0), addr: alu_addr, data: alu_data};
      end else if (win == LSU) begin
        m_out = '{we: (lsu_addr != 0), addr: lsu_addr, data: lsu_data};
      end else begin
        m_out.we = 1'b0;
      end
      if (win >= 0) begin
        m_last_winner = win;
        if (m_out.we) m_rf[m_out.addr] = m_out.data;
      end
    end
    check("alu_ready", alu_ready, (win == ALU));
    check("lsu_ready", lsu_ready, (win == LSU));
    g_alu = (win == ALU);
    g_lsu = (win == LSU);
    exp_q.push_back(m_out);
  endtask

  task automatic drive();
    txn_t t;
    if (g_alu) alu_valid = 1'b0;
    if (g_lsu) lsu_valid = 1'b0;
    g_alu = 1'b0;
    g_lsu = 1'b0;
    if (!alu_valid && alu_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
      t = alu_q.pop_front();
      alu_valid = 1'b1;
      alu_addr  = t.addr;
      alu_data  = t.data;
    end
    if (!lsu_valid && lsu_q.size() > 0 && (!gaps || $urandom_range(3) != 0)) begin
      t = lsu_q.pop_front();
      lsu_valid = 1'b1;
      lsu_addr  = t.addr;
      lsu_data  = t.data;
    end
    if (byp_auto) begin
      case ($urandom_range(3))
        0:       byp_addr_rs1 = 5'd0;
        1:       byp_addr_rs1 = 5'($urandom_range(31));
        default: byp_addr_rs1 = m_out.addr;
      endcase
      byp_addr_rs2 = ($urandom_range(1) == 0) ? m_out.addr : 5'($urandom_range(31));
    end
  endtask

  task automatic cycle();
    @(negedge r_clk);
    #1;
    model_step();
    @(posedge r_clk);
    #1;
    drive();
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while ((alu_valid || lsu_valid || alu_q.size() > 0 || lsu_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_errors++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", n);
    end
    cycle();
    cycle();
  endtask

  // Monitor: every cycle the DUT presents one output-stage state; compare it with the oldest prediction.
  initial begin
    out_t e;
    forever begin
      @(negedge r_clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL scoreboard_empty: no prediction for output at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("r_we", r_we, e.we);
        check("r_addr_rd", r_addr_rd, e.addr);
        check("r_data_rd", r_data_rd, e.data);
        check("byp_hit_rs1", byp_hit_rs1, e.we && e.addr == byp_addr_rs1 && byp_addr_rs1 != 0);
        check("byp_hit_rs2", byp_hit_rs2, e.we && e.addr == byp_addr_rs2 && byp_addr_rs2 != 0);
        check("byp_data_rs1", byp_data_rs1,
              (e.we && e.addr == byp_addr_rs1 && byp_addr_rs1 != 0) ? e.data : 32'h0);
        check("byp_data_rs2", byp_data_rs2,
              (e.we && e.addr == byp_addr_rs2 && byp_addr_rs2 != 0) ? e.data : 32'h0);
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_rf[i]  = '0;
      tb_rf[i] = '0;
    end
    r_rst         = 1'b1;
    alu_valid     = 1'b0;
    lsu_valid     = 1'b0;
    alu_addr      = '0;
    lsu_addr      = '0;
    alu_data      = '0;
    lsu_data      = '0;
    byp_addr_rs1  = '0;
    byp_addr_rs2  = '0;
    m_out         = '0;
    m_last_winner = LSU;
    g_alu         = 1'b0;
    g_lsu         = 1'b0;
    gaps          = 1'b0;
    byp_auto      = 1'b0;
    exp_q.push_back('0);

    // Reset with both requesters valid, then contention on release.
    for (int i = 1; i <= 4; i++) begin
      alu_q.push_back('{addr: 5'(i), data: 32'h100 + 32'(i)});
      lsu_q.push_back('{addr: 5'(10 + i), data: 32'h200 + 32'(i)});
    end
    drive();
    cycle();
    cycle();
    r_rst = 1'b0;
    run_until_idle(20);

    // Single ALU write.
    alu_q.push_back('{addr: 5'd5, data: 32'hA5});
    run_until_idle(10);

    // Write to x0 with rs1 looking at x0.
    byp_addr_rs1 = 5'd0;
    byp_addr_rs2 = 5'd0;
    lsu_q.push_back('{addr: 5'd0, data: 32'hFFFF});
    run_until_idle(10);

    // Bypass hit on rs1, miss on rs2.
    byp_addr_rs1 = 5'd7;
    byp_addr_rs2 = 5'd8;
    alu_q.push_back('{addr: 5'd7, data: 32'h1234});
    run_until_idle(10);

    // Reset in the middle of contention.
    for (int i = 0; i < 4; i++) begin
      alu_q.push_back('{addr: 5'(20 + i), data: $urandom});
      lsu_q.push_back('{addr: 5'(24 + i), data: $urandom});
    end
    cycle();
    cycle();
    cycle();
    r_rst = 1'b1;
    cycle();
    r_rst = 1'b0;
    run_until_idle(30);

    // Randomized traffic with occasional resets and address collisions.
    gaps     = 1'b1;
    byp_auto = 1'b1;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(2) == 0)
        alu_q.push_back('{addr: ($urandom_range(3) == 0) ? 5'd3 : 5'($urandom_range(31)), data: $urandom});
      if ($urandom_range(2) == 0)
        lsu_q.push_back('{addr: ($urandom_range(3) == 0) ? 5'd3 : 5'($urandom_range(31)), data: $urandom});
      r_rst = ($urandom_range(49) == 0);
      cycle();
    end
    r_rst = 1'b0;
    run_until_idle(2000);

    for (int i = 0; i < 32; i++) begin
      check($sformatf("regfile_x%0d", i), tb_rf[i], m_rf[i]);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
